// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the integer issue/writeback slice.
package riscv_pkg;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'd0,
        F3_SLL     = 3'd1,
        F3_SLT     = 3'd2,
        F3_SLTU    = 3'd3,
        F3_XOR     = 3'd4,
        F3_SRL_SRA = 3'd5,
        F3_OR      = 3'd6,
        F3_AND     = 3'd7
    } funct3_e;

    // Shift-immediates carry a 5-bit shamt instead of a 12-bit immediate.
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 integer register file: two combinational read ports, a debug read port and one write
// port. x0 is never written and always reads zero.
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];

    // Register storage; cleared asynchronously, x0 writes dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Reads see current contents only; a same-cycle write shows up next cycle.
    always_comb begin
        rd1      = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
        rd2      = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
        dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];
    end

endmodule

// File: rtl/riscv_alu_issue.sv
// Issue/writeback stage for the integer ALU: decodes OP / OP-IMM, reads operands (with optional
// bypass of the in-flight result), drives registered operands to the ALU and retires its result.
module riscv_alu_issue
    import riscv_pkg::*;
#(
    parameter int unsigned FORWARD = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        is_op_alu,
    output logic        is_op_alu_imm,
    output logic [2:0]  op_funct3,
    output logic [6:0]  op_funct7,
    output logic [31:0] reg_s1,
    output logic [31:0] reg_s2,
    output logic [31:0] imm,
    input  logic [31:0] rd_alu,
    output logic        retire_valid,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_value,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam bit Bypass = (FORWARD != 0);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic        dec_op, dec_imm, legal;
    logic [31:0] imm_val;
    logic [31:0] rf_rs1, rf_rs2;
    logic        hit1, hit2, stall, accept;
    logic [31:0] s1_val, s2_val;

    logic        e_valid_d, e_valid_q;
    logic        e_op_d, e_op_q;
    logic        e_imm_d, e_imm_q;
    logic [2:0]  e_f3_d, e_f3_q;
    logic [6:0]  e_f7_d, e_f7_q;
    logic [31:0] e_s1_d, e_s1_q;
    logic [31:0] e_s2_d, e_s2_q;
    logic [31:0] e_iv_d, e_iv_q;
    logic [4:0]  e_rd_d, e_rd_q;

    logic        ret_valid_d, ret_valid_q;
    logic [4:0]  ret_rd_d, ret_rd_q;
    logic [31:0] ret_value_d, ret_value_q;
    logic        illegal_d, illegal_q;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Decode legality and form the immediate.
    always_comb begin
        dec_op  = 1'b0;
        dec_imm = 1'b0;
        imm_val = 32'd0;
        if (opcode == OPC_OP) begin
            dec_op = (funct7 == FUNCT7_BASE) ||
                     ((funct7 == FUNCT7_ALT) &&
                      ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
        end else if (opcode == OPC_OP_IMM) begin
            if (funct3 == F3_SLL) begin
                dec_imm = (funct7 == FUNCT7_BASE);
            end else if (funct3 == F3_SRL_SRA) begin
                dec_imm = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
            end else begin
                dec_imm = 1'b1;
            end
            imm_val = is_shift(funct3) ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
        end
        legal = dec_op || dec_imm;
    end

    riscv_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .ra1      (rs1),
        .ra2      (rs2),
        .rd1      (rf_rs1),
        .rd2      (rf_rs2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (e_valid_q),
        .waddr    (e_rd_q),
        .wdata    (rd_alu)
    );

    // RAW detection against the E-stage destination; bypass or stall depending on FORWARD.
    always_comb begin
        hit1        = e_valid_q && (e_rd_q != 5'd0) && legal && (e_rd_q == rs1);
        hit2        = e_valid_q && (e_rd_q != 5'd0) && dec_op && (e_rd_q == rs2);
        stall       = !Bypass && instr_valid && (hit1 || hit2);
        instr_ready = reset && !stall;
        accept      = instr_valid && instr_ready;
        s1_val      = (Bypass && hit1) ? rd_alu : rf_rs1;
        s2_val      = dec_op ? ((Bypass && hit2) ? rd_alu : rf_rs2) : 32'd0;
    end

    // E-stage next state: load on a legal transfer, otherwise a zeroed bubble.
    always_comb begin
        e_valid_d = 1'b0;
        e_op_d    = 1'b0;
        e_imm_d   = 1'b0;
        e_f3_d    = 3'd0;
        e_f7_d    = 7'd0;
        e_s1_d    = 32'd0;
        e_s2_d    = 32'd0;
        e_iv_d    = 32'd0;
        e_rd_d    = 5'd0;
        if (accept && legal) begin
            e_valid_d = 1'b1;
            e_op_d    = dec_op;
            e_imm_d   = dec_imm;
            e_f3_d    = funct3;
            e_f7_d    = funct7;
            e_s1_d    = s1_val;
            e_s2_d    = s2_val;
            e_iv_d    = imm_val;
            e_rd_d    = rd;
        end
        ret_valid_d = e_valid_q;
        ret_rd_d    = e_valid_q ? e_rd_q : 5'd0;
        ret_value_d = e_valid_q ? rd_alu : 32'd0;
        illegal_d   = accept && !legal;
    end

    // E-stage and retire registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_valid_q   <= 1'b0;
            e_op_q      <= 1'b0;
            e_imm_q     <= 1'b0;
            e_f3_q      <= 3'd0;
            e_f7_q      <= 7'd0;
            e_s1_q      <= 32'd0;
            e_s2_q      <= 32'd0;
            e_iv_q      <= 32'd0;
            e_rd_q      <= 5'd0;
            ret_valid_q <= 1'b0;
            ret_rd_q    <= 5'd0;
            ret_value_q <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            e_valid_q   <= e_valid_d;
            e_op_q      <= e_op_d;
            e_imm_q     <= e_imm_d;
            e_f3_q      <= e_f3_d;
            e_f7_q      <= e_f7_d;
            e_s1_q      <= e_s1_d;
            e_s2_q      <= e_s2_d;
            e_iv_q      <= e_iv_d;
            e_rd_q      <= e_rd_d;
            ret_valid_q <= ret_valid_d;
            ret_rd_q    <= ret_rd_d;
            ret_value_q <= ret_value_d;
            illegal_q   <= illegal_d;
        end
    end

    assign is_op_alu     = e_op_q;
    assign is_op_alu_imm = e_imm_q;
    assign op_funct3     = e_f3_q;
    assign op_funct7     = e_f7_q;
    assign reg_s1        = e_s1_q;
    assign reg_s2        = e_s2_q;
    assign imm           = e_iv_q;
    assign retire_valid  = ret_valid_q;
    assign retire_rd     = ret_rd_q;
    assign retire_value  = ret_value_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed bench: instance 0 uses FORWARD=1, instance 1 uses FORWARD=0; both share clock/reset.
module tb_riscv_alu_issue;

    logic        clock;
    logic        reset;
    logic        instr_valid   [2];
    logic        instr_ready   [2];
    logic [31:0] instr         [2];
    logic        is_op_alu     [2];
    logic        is_op_alu_imm [2];
    logic [2:0]  op_funct3     [2];
    logic [6:0]  op_funct7     [2];
    logic [31:0] reg_s1        [2];
    logic [31:0] reg_s2        [2];
    logic [31:0] imm           [2];
    logic [31:0] rd_alu        [2];
    logic        retire_valid  [2];
    logic [4:0]  retire_rd     [2];
    logic [31:0] retire_value  [2];
    logic        illegal       [2];
    logic [4:0]  dbg_addr      [2];
    logic [31:0] dbg_data      [2];

    int n_cmp = 0;
    int n_bad = 0;

    riscv_alu_issue #(.FORWARD(1)) u_fwd (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]), .instr(instr[0]),
        .is_op_alu(is_op_alu[0]), .is_op_alu_imm(is_op_alu_imm[0]),
        .op_funct3(op_funct3[0]), .op_funct7(op_funct7[0]),
        .reg_s1(reg_s1[0]), .reg_s2(reg_s2[0]), .imm(imm[0]), .rd_alu(rd_alu[0]),
        .retire_valid(retire_valid[0]), .retire_rd(retire_rd[0]),
        .retire_value(retire_value[0]), .illegal(illegal[0]),
        .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
    );

    riscv_alu_issue #(.FORWARD(0)) u_stall (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]), .instr(instr[1]),
        .is_op_alu(is_op_alu[1]), .is_op_alu_imm(is_op_alu_imm[1]),
        .op_funct3(op_funct3[1]), .op_funct7(op_funct7[1]),
        .reg_s1(reg_s1[1]), .reg_s2(reg_s2[1]), .imm(imm[1]), .rd_alu(rd_alu[1]),
        .retire_valid(retire_valid[1]), .retire_rd(retire_rd[1]),
        .retire_value(retire_value[1]), .illegal(illegal[1]),
        .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
    );

    // Reference integer ALU the stage drives.
    function automatic logic [31:0] alu(input logic op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b_reg, input logic [31:0] iv);
        logic [31:0] b;
        b = op ? b_reg : iv;
        case (f3)
            3'd0:    return (op && f7[5]) ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {31'd0, $signed(a) < $signed(b)};
            3'd3:    return {31'd0, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign rd_alu[0] = alu(is_op_alu[0], op_funct3[0], op_funct7[0], reg_s1[0], reg_s2[0], imm[0]);
    assign rd_alu[1] = alu(is_op_alu[1], op_funct3[1], op_funct7[1], reg_s1[1], reg_s2[1], imm[1]);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word, wait (bounded) for ready, return at edge+1 of the cycle after accept.
    task automatic send(input int d, input logic [31:0] w, output int stalls);
        instr_valid[d] = 1'b1;
        instr[d]       = w;
        stalls         = 0;
        #1;
        while (instr_ready[d] !== 1'b1 && stalls < 8) begin
            stalls++;
            @(posedge clock);
            #2;
        end
        n_cmp++;
        if (instr_ready[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL send_timeout dut%0d word=%h stalls=%0d", d, w, stalls);
        end
        @(posedge clock);
        #1;
        instr_valid[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_cmp += 3;
            if (instr_ready[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_ready dut%0d got=%b want=0", d, instr_ready[d]);
            end
            if (retire_valid[d] !== 1'b0) begin
                n_bad++; $display("FAIL reset_retire dut%0d got=%b want=0", d, retire_valid[d]);
            end
            if (imm[d] !== 32'd0) begin
                n_bad++; $display("FAIL reset_imm dut%0d got=%h want=0", d, imm[d]);
            end
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_addi();
        int s;
        dbg_addr[0] = 5'd1;
        send(0, 32'h0050_0093, s);
        // N+1: operands on the ALU interface
        n_cmp += 4;
        if (is_op_alu_imm[0] !== 1'b1 || is_op_alu[0] !== 1'b0) begin
            n_bad++; $display("FAIL addi_kind got=%b%b want=01", is_op_alu[0], is_op_alu_imm[0]);
        end
        if (imm[0] !== 32'd5) begin
            n_bad++; $display("FAIL addi_imm got=%h want=5", imm[0]);
        end
        if (retire_valid[0] !== 1'b0) begin
            n_bad++; $display("FAIL addi_early_retire got=%b want=0", retire_valid[0]);
        end
        if (dbg_data[0] !== 32'd0) begin
            n_bad++; $display("FAIL addi_dbg_before got=%h want=0", dbg_data[0]);
        end
        tick();
        // N+2: retire pulse and written register
        n_cmp += 4;
        if (retire_valid[0] !== 1'b1) begin
            n_bad++; $display("FAIL addi_retire got=%b want=1", retire_valid[0]);
        end
        if (retire_rd[0] !== 5'd1) begin
            n_bad++; $display("FAIL addi_rd got=%0d want=1", retire_rd[0]);
        end
        if (retire_value[0] !== 32'd5) begin
            n_bad++; $display("FAIL addi_value got=%h want=5", retire_value[0]);
        end
        if (dbg_data[0] !== 32'd5) begin
            n_bad++; $display("FAIL addi_dbg got=%h want=5", dbg_data[0]);
        end
        tick();
        n_cmp += 2;
        if (retire_valid[0] !== 1'b0) begin
            n_bad++; $display("FAIL addi_pulse got=%b want=0", retire_valid[0]);
        end
        if (is_op_alu_imm[0] !== 1'b0 || reg_s1[0] !== 32'd0 || imm[0] !== 32'd0) begin
            n_bad++; $display("FAIL bubble got=%b/%h/%h want=0/0/0",
                              is_op_alu_imm[0], reg_s1[0], imm[0]);
        end
    endtask

    // ADDI x1,-1 ; SRAI x2,x1,4 ; SRLI x3,x1,4 back to back on instance d.
    task automatic test_chain(input int d, input int exp_stall);
        int s0, s1, s2;
        send(d, 32'hFFF0_0093, s0);
        send(d, 32'h4040_D113, s1);
        n_cmp += 3;
        if (reg_s1[d] !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL chain_srai_s1 dut%0d got=%h want=ffffffff", d, reg_s1[d]);
        end
        if (imm[d] !== 32'd4) begin
            n_bad++; $display("FAIL chain_srai_imm dut%0d got=%h want=4", d, imm[d]);
        end
        if (op_funct7[d] !== 7'h20) begin
            n_bad++; $display("FAIL chain_srai_f7 dut%0d got=%h want=20", d, op_funct7[d]);
        end
        send(d, 32'h0040_D193, s2);
        tick();
        tick();
        n_cmp += 4;
        if (s0 !== 0 || s2 !== 0) begin
            n_bad++; $display("FAIL chain_other_stalls dut%0d got=%0d,%0d want=0,0", d, s0, s2);
        end
        if (s1 !== exp_stall) begin
            n_bad++; $display("FAIL chain_srai_stall dut%0d got=%0d want=%0d", d, s1, exp_stall);
        end
        dbg_addr[d] = 5'd2;
        #1;
        if (dbg_data[d] !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL chain_x2 dut%0d got=%h want=ffffffff", d, dbg_data[d]);
        end
        dbg_addr[d] = 5'd3;
        #1;
        if (dbg_data[d] !== 32'h0FFF_FFFF) begin
            n_bad++; $display("FAIL chain_x3 dut%0d got=%h want=0fffffff", d, dbg_data[d]);
        end
    endtask

    task automatic test_x0_and_sltiu();
        int s;
        send(0, 32'hFFF0_3213, s);
        tick();
        tick();
        dbg_addr[0] = 5'd4;
        #1;
        n_cmp++;
        if (dbg_data[0] !== 32'd1) begin
            n_bad++; $display("FAIL sltiu_x4 got=%h want=1", dbg_data[0]);
        end
        send(0, 32'h0070_0013, s);
        tick();
        n_cmp += 3;
        if (retire_valid[0] !== 1'b1 || retire_rd[0] !== 5'd0) begin
            n_bad++; $display("FAIL x0_retire got=%b rd=%0d want=1 rd=0",
                              retire_valid[0], retire_rd[0]);
        end
        if (retire_value[0] !== 32'd7) begin
            n_bad++; $display("FAIL x0_value got=%h want=7", retire_value[0]);
        end
        dbg_addr[0] = 5'd0;
        #1;
        if (dbg_data[0] !== 32'd0) begin
            n_bad++; $display("FAIL x0_dbg got=%h want=0", dbg_data[0]);
        end
        send(0, 32'h0000_02B3, s);
        n_cmp++;
        if (is_op_alu[0] !== 1'b1 || reg_s2[0] !== 32'd0) begin
            n_bad++; $display("FAIL add_kind got=%b s2=%h want=1 s2=0", is_op_alu[0], reg_s2[0]);
        end
        tick();
        n_cmp++;
        if (retire_valid[0] !== 1'b1 || retire_rd[0] !== 5'd5 || retire_value[0] !== 32'd0) begin
            n_bad++; $display("FAIL add_retire got=%b/%0d/%h want=1/5/0",
                              retire_valid[0], retire_rd[0], retire_value[0]);
        end
    endtask

    task automatic test_illegal();
        int s;
        logic [31:0] words [2];
        words[0] = 32'h0000_2083;
        words[1] = 32'h0220_8033;
        dbg_addr[0] = 5'd1;
        for (int k = 0; k < 2; k++) begin
            send(0, words[k], s);
            n_cmp += 2;
            if (illegal[0] !== 1'b1) begin
                n_bad++; $display("FAIL illegal_pulse w=%h got=%b want=1", words[k], illegal[0]);
            end
            if (is_op_alu[0] !== 1'b0 || is_op_alu_imm[0] !== 1'b0) begin
                n_bad++; $display("FAIL illegal_entered_e w=%h got=%b%b want=00",
                                  words[k], is_op_alu[0], is_op_alu_imm[0]);
            end
            tick();
            n_cmp += 3;
            if (illegal[0] !== 1'b0) begin
                n_bad++; $display("FAIL illegal_width w=%h got=%b want=0", words[k], illegal[0]);
            end
            if (retire_valid[0] !== 1'b0) begin
                n_bad++; $display("FAIL illegal_retire w=%h got=%b want=0", words[k],
                                  retire_valid[0]);
            end
            if (dbg_data[0] !== 32'hFFFF_FFFF) begin
                n_bad++; $display("FAIL illegal_x1 w=%h got=%h want=ffffffff", words[k],
                                  dbg_data[0]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int s;
        dbg_addr[0] = 5'd1;
        send(0, 32'h0050_0093, s);
        #2;
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (is_op_alu_imm[0] !== 1'b0 || imm[0] !== 32'd0 || retire_valid[0] !== 1'b0) begin
            n_bad++; $display("FAIL rst_outputs got=%b/%h/%b want=0/0/0",
                              is_op_alu_imm[0], imm[0], retire_valid[0]);
        end
        if (instr_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL rst_ready_low got=%b want=0", instr_ready[0]);
        end
        if (dbg_data[0] !== 32'd0) begin
            n_bad++; $display("FAIL rst_x1_cleared got=%h want=0", dbg_data[0]);
        end
        tick();
        n_cmp++;
        if (retire_valid[0] !== 1'b0 || dbg_data[0] !== 32'd0) begin
            n_bad++; $display("FAIL rst_no_retire got=%b x1=%h want=0 x1=0",
                              retire_valid[0], dbg_data[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp += 2;
        if (instr_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL rst_release_ready0 got=%b want=1", instr_ready[0]);
        end
        if (instr_ready[1] !== 1'b1) begin
            n_bad++; $display("FAIL rst_release_ready1 got=%b want=1", instr_ready[1]);
        end
        tick();
        n_cmp++;
        if (retire_valid[0] !== 1'b0 || dbg_data[0] !== 32'd0) begin
            n_bad++; $display("FAIL rst_after got=%b x1=%h want=0 x1=0",
                              retire_valid[0], dbg_data[0]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            instr_valid[d] = 1'b0;
            instr[d]       = 32'd0;
            dbg_addr[d]    = 5'd0;
        end
        test_reset();
        test_addi();
        test_chain(0, 0);
        test_chain(1, 1);
        test_x0_and_sltiu();
        test_illegal();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
